// File: rtl/if_id_reg.sv
// IF/ID pipeline register: fetch-to-decode latch with stall, flush-to-bubble and a saturating stall counter.
// Optional fetch address-error (AdEL) detection is enabled by defining IF_ID_ADEL_EN.
module if_id_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc8,
    output logic [31:0] id_instr,
    output logic        id_valid,
    output logic [4:0]  id_exc,
    output logic [15:0] stall_cnt
);

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    logic [31:0] r_pc;
    logic [31:0] r_pc8;
    logic [31:0] r_instr;
    logic        r_valid;
    logic [15:0] r_stall_cnt;
    logic [31:0] w_pc8;
    logic [31:0] w_load_instr;
    logic [4:0]  w_load_exc;

    assign w_pc8 = pc + 32'd8;

`ifdef IF_ID_ADEL_EN
    logic [4:0] r_exc;
    logic       w_adel;

    // Misaligned or outside the instruction window: fetch is replaced by a nop tagged AdEL.
    assign w_adel       = (pc[1:0] != 2'b00) || (pc < 32'h0000_3000) || (pc > 32'h0000_6FFC);
    assign w_load_instr = w_adel ? NOP : instr;
    assign w_load_exc   = w_adel ? 5'd4 : 5'd0;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_exc <= '0;
        end else if (!stall) begin
            r_exc <= w_load_exc;
        end
    end

    assign id_exc = r_exc;
`else
    assign w_load_instr = instr;
    assign w_load_exc   = 5'd0;
    assign id_exc       = w_load_exc;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_pc8   <= RESET_PC + 32'd8;
            r_instr <= NOP;
            r_valid <= 1'b0;
        end else if (flush) begin
            r_pc    <= pc;
            r_pc8   <= w_pc8;
            r_instr <= NOP;
            r_valid <= 1'b0;
        end else if (!stall) begin
            r_pc    <= pc;
            r_pc8   <= w_pc8;
            r_instr <= w_load_instr;
            r_valid <= 1'b1;
        end
    end

    // Counts every stalled cycle, flushed ones included; sticks at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign id_pc     = r_pc;
    assign id_pc8    = r_pc8;
    assign id_instr  = r_instr;
    assign id_valid  = r_valid;
    assign stall_cnt = r_stall_cnt;

endmodule
